// File: rtl/controlador_pkg.sv
// Shared types and defaults for the cache controller.
// State encoding, bus width defaults and statistics counter width.
package controlador_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    WRITEBACK,
    FILL,
    RESPOND
  } estado_t;

endpackage

// File: rtl/controlador_cache_if.sv
// Processor-side request/response bundle of the cache controller.
// The processor is master; the controller is slave.
interface controlador_cache_if #(
  parameter int ADDR_W = controlador_pkg::DEF_ADDR_W,
  parameter int DATA_W = controlador_pkg::DEF_DATA_W
) ();

  logic              cpu_req;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_done, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_done, cpu_rdata
  );

endinterface

// File: rtl/contador_saturado.sv
// Statistics counter with increment enable.
// Sticks at all-ones instead of wrapping.
module contador_saturado
  import controlador_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/controlador_cache.sv
// Write-back, write-allocate cache controller: one word per line,
// dirty victim eviction to RAM, line fill on read miss.
module controlador_cache
  import controlador_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  controlador_cache_if.slave cpu,
  output logic              cache_lookup,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_tag,
  input  logic [DATA_W-1:0] victim_data,
  output logic              cache_fill,
  output logic [DATA_W-1:0] cache_fill_data,
  output logic              cache_fill_dirty,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  estado_t           r_state;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              r_lookup;
  logic              r_fill;
  logic [DATA_W-1:0] r_fill_data;
  logic              r_fill_dirty;
  logic              r_ram_req;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              w_inc_hit;
  logic              w_inc_miss;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_rdata      <= '0;
      r_lookup     <= 1'b0;
      r_fill       <= 1'b0;
      r_fill_data  <= '0;
      r_fill_dirty <= 1'b0;
      r_ram_req    <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
    end else begin
      r_lookup <= 1'b0;
      r_fill   <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (cpu.cpu_req) begin
            r_write  <= cpu.cpu_write;
            r_addr   <= cpu.cpu_addr;
            r_wdata  <= cpu.cpu_wdata;
            r_lookup <= 1'b1;
            r_state  <= LOOKUP;
          end
        end
        LOOKUP: r_state <= CHECK;
        CHECK: begin
          if (cache_hit) begin
            if (r_write) begin
              r_fill       <= 1'b1;
              r_fill_data  <= r_wdata;
              r_fill_dirty <= 1'b1;
            end else begin
              r_rdata <= cache_rdata;
              r_done  <= 1'b1;
            end
            r_state <= RESPOND;
          end else if (victim_valid && victim_dirty) begin
            r_ram_req   <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= victim_tag;
            r_ram_wdata <= victim_data;
            r_state     <= WRITEBACK;
          end else if (r_write) begin
            r_fill       <= 1'b1;
            r_fill_data  <= r_wdata;
            r_fill_dirty <= 1'b1;
            r_state      <= RESPOND;
          end else begin
            r_ram_req  <= 1'b1;
            r_ram_we   <= 1'b0;
            r_ram_addr <= r_addr;
            r_state    <= FILL;
          end
        end
        WRITEBACK: begin
          if (ram_ack) begin
            r_ram_req <= 1'b0;
            r_ram_we  <= 1'b0;
            if (r_write) begin
              r_fill       <= 1'b1;
              r_fill_data  <= r_wdata;
              r_fill_dirty <= 1'b1;
              r_state      <= RESPOND;
            end else begin
              r_state <= FILL;
            end
          end
        end
        FILL: begin
          // after a writeback the request drops for a cycle before the read
          if (!r_ram_req) begin
            r_ram_req  <= 1'b1;
            r_ram_addr <= r_addr;
          end else if (ram_ack) begin
            r_ram_req    <= 1'b0;
            r_rdata      <= ram_rdata;
            r_fill       <= 1'b1;
            r_fill_data  <= ram_rdata;
            r_fill_dirty <= 1'b0;
            r_state      <= RESPOND;
          end
        end
        RESPOND: begin
          // a fill pulse occupies the first cycle; done follows it
          if (r_done) begin
            r_state <= IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_inc_hit  = (r_state == CHECK) && cache_hit;
  assign w_inc_miss = (r_state == CHECK) && !cache_hit;

  contador_saturado u_hits (
    .clock   (clock),
    .reset_n (reset_n),
    .i_inc   (w_inc_hit),
    .o_count (hit_count)
  );

  contador_saturado u_misses (
    .clock   (clock),
    .reset_n (reset_n),
    .i_inc   (w_inc_miss),
    .o_count (miss_count)
  );

  assign cpu.cpu_ready    = (r_state == IDLE);
  assign cpu.cpu_done     = r_done;
  assign cpu.cpu_rdata    = r_rdata;
  assign cache_lookup     = r_lookup;
  assign cache_addr       = r_addr;
  assign cache_fill       = r_fill;
  assign cache_fill_data  = r_fill_data;
  assign cache_fill_dirty = r_fill_dirty;
  assign ram_req          = r_ram_req;
  assign ram_we           = r_ram_we;
  assign ram_addr         = r_ram_addr;
  assign ram_wdata        = r_ram_wdata;

endmodule

// File: tb/tb_controlador_cache.sv
// Scoreboard bench for controlador_cache: hit, clean and dirty misses,
// busy/stray handling, counter saturation and reset mid-fill.
module tb_controlador_cache;
  import controlador_pkg::*;

  logic       clock;
  logic       reset_n;
  logic       cache_lookup;
  logic [7:0] cache_addr;
  logic       cache_hit;
  logic [7:0] cache_rdata;
  logic       victim_valid;
  logic       victim_dirty;
  logic [7:0] victim_tag;
  logic [7:0] victim_data;
  logic       cache_fill;
  logic [7:0] cache_fill_data;
  logic       cache_fill_dirty;
  logic       ram_req;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_ack;
  logic [7:0] ram_rdata;
  logic [7:0] hit_count;
  logic [7:0] miss_count;

  logic       resp_ack;
  logic       stray_ack;
  logic       ram_en;
  int         ram_lat;
  logic [7:0] ram_rd_val;
  int         wcnt;

  controlador_cache_if cpu_if ();

  assign ram_ack = resp_ack | stray_ack;

  controlador_cache dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .cpu              (cpu_if.slave),
    .cache_lookup     (cache_lookup),
    .cache_addr       (cache_addr),
    .cache_hit        (cache_hit),
    .cache_rdata      (cache_rdata),
    .victim_valid     (victim_valid),
    .victim_dirty     (victim_dirty),
    .victim_tag       (victim_tag),
    .victim_data      (victim_data),
    .cache_fill       (cache_fill),
    .cache_fill_data  (cache_fill_data),
    .cache_fill_dirty (cache_fill_dirty),
    .ram_req          (ram_req),
    .ram_we           (ram_we),
    .ram_addr         (ram_addr),
    .ram_wdata        (ram_wdata),
    .ram_ack          (ram_ack),
    .ram_rdata        (ram_rdata),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic       chk_rd;
    logic [7:0] rd;
    int         lat;
  } exp_t;

  exp_t sb[$];

  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int fill_cnt = 0;
  logic [7:0] last_ra, last_wa, last_wd, last_fd;
  logic last_fdirty;
  logic prev_req = 1'b0;

  always @(posedge clock) cyc++;

  // RAM model: ack after ram_lat cycles of asserted request
  always @(posedge clock) begin
    #1;
    resp_ack = 1'b0;
    if (ram_en && ram_req) begin
      wcnt++;
      if (wcnt >= ram_lat) begin
        resp_ack  = 1'b1;
        ram_rdata = ram_rd_val;
        wcnt      = 0;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    int n;
    if (reset_n && cpu_if.cpu_req && cpu_if.cpu_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (ram_req && !prev_req) begin
      if (ram_we) begin
        wr_cnt++;
        last_wa = ram_addr;
        last_wd = ram_wdata;
      end else begin
        rd_cnt++;
        last_ra = ram_addr;
      end
    end
    prev_req = ram_req;
    if (cache_fill) begin
      fill_cnt++;
      last_fd     = cache_fill_data;
      last_fdirty = cache_fill_dirty;
    end
    n = int'(cache_lookup) + int'(cache_fill) + int'(ram_req)
      + int'(cpu_if.cpu_done);
    if (n != 0) chk("strobe_excl", n, 1);
    if (cpu_if.cpu_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        if (e.chk_rd) chk("rdata", cpu_if.cpu_rdata, e.rd);
        if (e.lat >= 0) chk("done_lat", cyc - acc_cyc, e.lat);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input logic c, input logic [7:0] rd, input int lat);
    exp_t e;
    e.chk_rd = c;
    e.rd     = rd;
    e.lat    = lat;
    sb.push_back(e);
  endtask

  task automatic set_cache(input logic hit, input logic [7:0] crd,
                           input logic vv, input logic vd,
                           input logic [7:0] vt, input logic [7:0] vdat);
    cache_hit    = hit;
    cache_rdata  = crd;
    victim_valid = vv;
    victim_dirty = vd;
    victim_tag   = vt;
    victim_data  = vdat;
  endtask

  task automatic wait_done(input int tgt);
    for (int k = 0; k < 80 && done_cnt < tgt; k++) tick();
    chk("done_timeout", done_cnt >= tgt, 1);
  endtask

  task automatic access(input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] rrd,
                        input int lat, input logic chk_rd,
                        input logic [7:0] exp_rd, input int exp_lat);
    int d0;
    d0 = done_cnt;
    ram_rd_val = rrd;
    ram_lat    = lat;
    push(chk_rd, exp_rd, exp_lat);
    @(posedge clock);
    #1;
    cpu_if.cpu_write = wr;
    cpu_if.cpu_addr  = a;
    cpu_if.cpu_wdata = wd;
    cpu_if.cpu_req   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (cpu_if.cpu_ready) break;
    end
    @(posedge clock);
    #1;
    cpu_if.cpu_req = 1'b0;
    wait_done(d0 + 1);
  endtask

  int r0, w0, f0, d0, a0;
  logic [7:0] m0;

  initial begin
    reset_n          = 1'b0;
    cpu_if.cpu_req   = 1'b0;
    cpu_if.cpu_write = 1'b0;
    cpu_if.cpu_addr  = '0;
    cpu_if.cpu_wdata = '0;
    resp_ack         = 1'b0;
    stray_ack        = 1'b0;
    ram_en           = 1'b1;
    ram_lat          = 1;
    ram_rd_val       = '0;
    ram_rdata        = '0;
    wcnt             = 0;
    set_cache(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clock);
    tick();
    chk("rst_ready", cpu_if.cpu_ready, 1);
    chk("rst_done", cpu_if.cpu_done, 0);
    chk("rst_lookup", cache_lookup, 0);
    chk("rst_ramreq", ram_req, 0);
    chk("rst_rdata", cpu_if.cpu_rdata, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // read hit
    r0 = rd_cnt + wr_cnt; f0 = fill_cnt;
    set_cache(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00);
    access(1'b0, 8'h04, 8'h00, 8'h00, 1, 1'b1, 8'h05, 3);
    chk("hit_noram", rd_cnt + wr_cnt - r0, 0);
    chk("hit_nofill", fill_cnt - f0, 0);
    chk("hit_cnt", hit_count, 1);

    // clean read miss
    r0 = rd_cnt; w0 = wr_cnt; f0 = fill_cnt;
    set_cache(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 8'h33);
    access(1'b0, 8'h66, 8'h00, 8'h01, 4, 1'b1, 8'h01, -1);
    chk("cm_rd", rd_cnt - r0, 1);
    chk("cm_wr", wr_cnt - w0, 0);
    chk("cm_addr", last_ra, 8'h66);
    chk("cm_fill", fill_cnt - f0, 1);
    chk("cm_fdata", last_fd, 8'h01);
    chk("cm_fdirty", last_fdirty, 0);
    chk("cm_miss", miss_count, 1);

    // dirty write miss
    r0 = rd_cnt; w0 = wr_cnt; f0 = fill_cnt;
    set_cache(1'b0, 8'h00, 1'b1, 1'b1, 8'h64, 8'h07);
    access(1'b1, 8'h65, 8'hAA, 8'hEE, 2, 1'b0, 8'h00, -1);
    chk("dw_wr", wr_cnt - w0, 1);
    chk("dw_rd", rd_cnt - r0, 0);
    chk("dw_waddr", last_wa, 8'h64);
    chk("dw_wdata", last_wd, 8'h07);
    chk("dw_fill", fill_cnt - f0, 1);
    chk("dw_fdata", last_fd, 8'hAA);
    chk("dw_fdirty", last_fdirty, 1);
    chk("dw_rdhold", cpu_if.cpu_rdata, 8'h01);
    chk("dw_miss", miss_count, 2);

    // write hit
    r0 = rd_cnt + wr_cnt; f0 = fill_cnt;
    set_cache(1'b1, 8'h05, 1'b1, 1'b1, 8'h64, 8'h07);
    access(1'b1, 8'h04, 8'h3C, 8'h00, 1, 1'b0, 8'h00, -1);
    chk("wh_noram", rd_cnt + wr_cnt - r0, 0);
    chk("wh_fill", fill_cnt - f0, 1);
    chk("wh_fdata", last_fd, 8'h3C);
    chk("wh_fdirty", last_fdirty, 1);
    chk("wh_hits", hit_count, 2);

    // dirty read miss: writeback then fill
    r0 = rd_cnt; w0 = wr_cnt; f0 = fill_cnt;
    set_cache(1'b0, 8'h00, 1'b1, 1'b1, 8'h50, 8'h77);
    access(1'b0, 8'h12, 8'h00, 8'h42, 1, 1'b1, 8'h42, -1);
    chk("dr_wr", wr_cnt - w0, 1);
    chk("dr_waddr", last_wa, 8'h50);
    chk("dr_wdata", last_wd, 8'h77);
    chk("dr_rd", rd_cnt - r0, 1);
    chk("dr_raddr", last_ra, 8'h12);
    chk("dr_fill", fill_cnt - f0, 1);
    chk("dr_fdata", last_fd, 8'h42);
    chk("dr_miss", miss_count, 3);

    // busy: request held through a miss, stray ack while idle on RAM
    r0 = rd_cnt; f0 = fill_cnt; d0 = done_cnt; a0 = acc_cnt;
    set_cache(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    ram_rd_val = 8'h99;
    ram_lat    = 3;
    push(1'b1, 8'h99, -1);
    push(1'b1, 8'hC3, 3);
    @(posedge clock);
    #1;
    cpu_if.cpu_write = 1'b0;
    cpu_if.cpu_addr  = 8'h30;
    cpu_if.cpu_req   = 1'b1;
    for (int k = 0; k < 20 && acc_cnt == a0; k++) tick();
    chk("busy_acc1", acc_cnt - a0, 1);
    @(posedge clock);
    #1;
    stray_ack = 1'b1;
    @(posedge clock);
    #1;
    stray_ack = 1'b0;
    wait_done(d0 + 1);
    chk("busy_held", acc_cnt - a0, 1);
    set_cache(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 20 && acc_cnt == a0 + 1; k++) tick();
    chk("busy_acc2", acc_cnt - a0, 2);
    @(posedge clock);
    #1;
    cpu_if.cpu_req = 1'b0;
    wait_done(d0 + 2);
    chk("busy_rd", rd_cnt - r0, 1);
    chk("busy_fill", fill_cnt - f0, 1);
    chk("busy_miss", miss_count, 4);
    chk("busy_hits", hit_count, 3);

    // saturation
    m0 = miss_count;
    for (int i = 0; i < 260; i++) begin
      set_cache(1'b1, 8'(i) ^ 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
      access(1'b0, 8'(i), 8'h00, 8'h00, 1, 1'b1, 8'(i) ^ 8'h5A, 3);
    end
    chk("sat_hits", hit_count, 255);
    chk("sat_miss", miss_count, m0);

    // reset two cycles into FILL, then a late ack
    ram_en = 1'b0;
    f0 = fill_cnt; d0 = done_cnt;
    set_cache(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clock);
    #1;
    cpu_if.cpu_addr = 8'h77;
    cpu_if.cpu_req  = 1'b1;
    @(posedge clock);
    #1;
    cpu_if.cpu_req = 1'b0;
    for (int k = 0; k < 20 && !ram_req; k++) tick();
    chk("rf_req_up", ram_req, 1);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rf_req_down", ram_req, 0);
    chk("rf_ready", cpu_if.cpu_ready, 1);
    chk("rf_hits0", hit_count, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    stray_ack = 1'b1;
    @(posedge clock);
    #1;
    stray_ack = 1'b0;
    repeat (5) tick();
    chk("rf_nofill", fill_cnt - f0, 0);
    chk("rf_nodone", done_cnt - d0, 0);
    chk("rf_hits", hit_count, 0);
    chk("rf_miss", miss_count, 0);
    chk("rf_idle", cpu_if.cpu_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
